imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory responder for the CPU instruction-fetch port. The CPU drives
//  iaddr; this block returns idata. Word-addressed storage, programmable wait states,
//  valid/ready request and response channels, plus a test-load write port.
//  Sits between the CPU fetch stage and the bench or boot loader. Replaces the
//  bench-local instruction array.
// PARAMETERS
//  DEPTH        16            number of 32-bit instruction words (power of two, >=2)
//  WAIT_STATES  1             extra cycles between request accept and response (0..15)
//  FILL_WORD    32'h00000013  initial content of every word, and idata on error (NOP)
//  IDX_W        $clog2(DEPTH) word-index width (derived; do not override)
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  reset      in   1      asynchronous, active-low reset
//  req_valid  in   1      CPU presents a fetch request
//  req_ready  out  1      responder accepts a request (high only in IDLE)
//  iaddr      in   32     byte address of instruction; sampled on accept
//  rsp_valid  out  1      idata/rsp_err valid
//  rsp_ready  in   1      CPU consumes the response
//  idata      out  32     fetched instruction word
//  rsp_err    out  1      misaligned (iaddr[1:0]!=0) or out-of-range (iaddr>=DEPTH*4)
//  load_en    in   1      write load_data into word load_idx this cycle
//  load_idx   in   IDX_W  word index for load
//  load_data  in   32     word to store
//  busy       out  1      request accepted and not yet consumed (state != IDLE)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, busy=0,
//   idata=FILL_WORD, wait counter=0, latched address=0. Storage is NOT cleared by reset.
//   Storage holds FILL_WORD in every word at time zero.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid, latch iaddr. If WAIT_STATES==0, go to RESP.
//    Otherwise load counter=WAIT_STATES-1 and go to WAIT.
//   WAIT: req_ready=0. Decrement the counter each cycle. Go to RESP after the cycle in
//    which counter==0.
//   RESP: rsp_valid=1. Hold idata and rsp_err stable until rsp_ready. On rsp_ready, go to
//    IDLE. No back-to-back accept in the same cycle; a new request is taken one cycle
//    later in IDLE.
//  Latency: accept edge to rsp_valid high = WAIT_STATES+1 clocks.
//  Read: word index = latched iaddr[IDX_W+1:2]. idata is registered on entry to RESP.
//  Error: rsp_err=1 and idata=FILL_WORD when latched iaddr[1:0]!=0 or
//   latched iaddr[31:IDX_W+2]!=0. Storage is not read. The handshake is unchanged.
//  Load port: works in any state, one word per cycle.
//   Load to the word being read on the RESP-entry edge: idata gets the OLD value
//    (read-before-write).
//   Later loads do not change a held idata.
//  req_valid while not IDLE is ignored. The CPU must hold the request until req_ready.
//  Reset asserted mid-transaction: the pending fetch is dropped, outputs take reset
//   values immediately, and no response is produced after release.
//  Counter width is 4 bits. WAIT_STATES>15 is illegal; check it at elaboration.
// STRUCTURE
//  Shared package cpu_pkg holds:
//   - RV_NOP = 32'h00000013
//   - the fetch FSM state typedef/localparams {IDLE, WAIT, RESP}
//   - XLEN = 32
//  Sub-module imem_array: DEPTH x 32 storage with one synchronous write port
//   (load_en/load_idx/load_data) and one synchronous read port with read enable.
//   Read-before-write on the same index.
//  Top level holds the FSM, wait counter, address latch, error decode and output
//   registers.
// TESTING
//  1 Reset: hold reset=0 for 3 clocks, then release
//    -> req_ready=1, rsp_valid=0, busy=0, idata=32'h00000013.
//  2 Load then fetch: load idx0=32'h00500093, idx1=32'h00108133.
//    Fetch iaddr=0 with WAIT_STATES=1 -> rsp_valid exactly 2 clocks after accept,
//    idata=32'h00500093, rsp_err=0. Then iaddr=4 -> 32'h00108133.
//  3 Back-pressure: hold rsp_ready=0 for 5 clocks in RESP -> idata and rsp_valid stable,
//    req_ready=0. Assert rsp_ready -> IDLE next clock.
//  4 Errors: iaddr=32'h2 -> rsp_err=1, idata=32'h00000013.
//    iaddr=32'h40 (DEPTH=16) -> rsp_err=1. iaddr=32'h3C -> rsp_err=0, returns word 15.
//  5 Collision and zero wait: WAIT_STATES=0, load idx3=32'hDEADBEEF on the RESP-entry
//    edge of fetch iaddr=12 -> old word returned. The next fetch of 12 -> 32'hDEADBEEF.
//    Latency = 1 clock.
//  6 Reset mid-WAIT: WAIT_STATES=4, pulse reset low 2 clocks after accept -> rsp_valid
//    never rises for that fetch. Loaded contents survive: re-fetch returns the stored word.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, canonical NOP and
// the instruction-fetch responder state encoding.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and
// one registered read port; a same-index read returns the old word.
module imem_array
    import cpu_pkg::*;
#(
    parameter int              DEPTH     = 16,
    parameter logic [XLEN-1:0] FILL_WORD = RV_NOP,
    parameter int              IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [XLEN-1:0]  rdata_o
);

    // Contents power up as FILL_WORD and are never cleared by reset.
    logic [XLEN-1:0] mem_q [DEPTH] = '{default: FILL_WORD};
    logic [XLEN-1:0] rdata_q;

    // Load port: one word per cycle, independent of the fetch FSM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Read register samples pre-write contents on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= FILL_WORD;
        end else if (re_i) begin
            rdata_q <= mem_q[ridx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: valid/ready request and response,
// programmable wait states, range/alignment check and a load port.
module imem_fetch_responder
    import cpu_pkg::*;
#(
    parameter int              DEPTH       = 16,
    parameter int              WAIT_STATES = 1,
    parameter logic [XLEN-1:0] FILL_WORD   = RV_NOP,
    parameter int              IDX_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  iaddr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  idata,
    output logic             rsp_err,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [XLEN-1:0]  load_data,
    output logic             busy
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("imem_fetch_responder: WAIT_STATES must be 0..15");
    end

    if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
        $error("imem_fetch_responder: DEPTH must be a power of two >= 2");
    end

    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT  =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    fetch_state_e    state_q;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] addr_q;
    logic            rsp_err_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            busy_q;

    logic [XLEN-1:0] rd_addr;
    logic            addr_err;
    logic            enter_resp;
    logic            rd_en;
    logic [XLEN-1:0] rdata;

    // With zero wait states the read happens on the accept edge,
    // before the address latch has been written.
    always_comb begin
        rd_addr    = (state_q == IDLE) ? iaddr : addr_q;
        addr_err   = (|rd_addr[1:0]) || (|rd_addr[XLEN-1:IDX_W+2]);
        enter_resp = (state_q == IDLE && req_valid && ZERO_WAIT)
                  || (state_q == WAIT && cnt_q == 4'd0);
        rd_en      = enter_resp && !addr_err;
    end

    imem_array #(
        .DEPTH     (DEPTH),
        .FILL_WORD (FILL_WORD),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (load_en),
        .widx_i  (load_idx),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .ridx_i  (rd_addr[IDX_W+1:2]),
        .rdata_o (rdata)
    );

    // Fetch FSM with wait counter, address latch and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= iaddr;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= addr_err;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= addr_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign idata     = rsp_err_q ? FILL_WORD : rdata;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: three responders with 1, 0 and 4 wait states
// share clock and reset; each step checks hand-computed values.
module tb_imem_fetch_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] iaddr     [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] idata     [3];
    logic        rsp_err   [3];
    logic        load_en   [3];
    logic [3:0]  load_idx  [3];
    logic [31:0] load_data [3];
    logic        busy      [3];

    int errors = 0;
    int checks = 0;

    imem_fetch_responder #(.DEPTH(16), .WAIT_STATES(1)) u_w1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .iaddr(iaddr[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .idata(idata[0]),
        .rsp_err(rsp_err[0]), .load_en(load_en[0]),
        .load_idx(load_idx[0]), .load_data(load_data[0]),
        .busy(busy[0])
    );

    imem_fetch_responder #(.DEPTH(16), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .iaddr(iaddr[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .idata(idata[1]),
        .rsp_err(rsp_err[1]), .load_en(load_en[1]),
        .load_idx(load_idx[1]), .load_data(load_data[1]),
        .busy(busy[1])
    );

    imem_fetch_responder #(.DEPTH(16), .WAIT_STATES(4)) u_w4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .iaddr(iaddr[2]), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .idata(idata[2]),
        .rsp_err(rsp_err[2]), .load_en(load_en[2]),
        .load_idx(load_idx[2]), .load_data(load_data[2]),
        .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [3:0] idx,
                        input logic [31:0] data);
        load_en[k]   = 1'b1;
        load_idx[k]  = idx;
        load_data[k] = data;
        tick();
        load_en[k]   = 1'b0;
    endtask

    // Accept edge counts as clock 1; leaves the DUT in RESP.
    task automatic start_fetch(input int k, input logic [31:0] addr,
                               output int lat);
        req_valid[k] = 1'b1;
        iaddr[k]     = addr;
        rsp_ready[k] = 1'b0;
        tick();
        req_valid[k] = 1'b0;
        iaddr[k]     = 32'hFFFF_FFFF;
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume(input int k);
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
    endtask

    int lat;
    int seen;
    logic [31:0] held;

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            iaddr[k]     = 32'h0;
            rsp_ready[k] = 1'b0;
            load_en[k]   = 1'b0;
            load_idx[k]  = 4'h0;
            load_data[k] = 32'h0;
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state on all three instances
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 32'd1);
            check($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("rst_err%0d", k), 32'(rsp_err[k]), 32'd0);
            check($sformatf("rst_idata%0d", k), idata[k], 32'h00000013);
        end

        // Load then fetch, one wait state
        load(0, 4'd0, 32'h00500093);
        load(0, 4'd1, 32'h00108133);
        start_fetch(0, 32'h0, lat);
        check("w1_lat0", 32'(lat), 32'd2);
        check("w1_valid0", 32'(rsp_valid[0]), 32'd1);
        check("w1_data0", idata[0], 32'h00500093);
        check("w1_err0", 32'(rsp_err[0]), 32'd0);
        check("w1_busy0", 32'(busy[0]), 32'd1);
        consume(0);
        start_fetch(0, 32'h4, lat);
        check("w1_lat4", 32'(lat), 32'd2);
        check("w1_data4", idata[0], 32'h00108133);
        consume(0);

        // Back-pressure, with a load to the held word mid-hold
        start_fetch(0, 32'h0, lat);
        held = idata[0];
        check("bp_first", held, 32'h00500093);
        load(0, 4'd0, 32'h11111111);
        repeat (4) tick();
        check("bp_data", idata[0], 32'h00500093);
        check("bp_valid", 32'(rsp_valid[0]), 32'd1);
        check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        consume(0);
        check("bp_idle_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        check("bp_idle_busy", 32'(busy[0]), 32'd0);
        load(0, 4'd0, 32'h00500093);

        // Error decode
        start_fetch(0, 32'h2, lat);
        check("mis_err", 32'(rsp_err[0]), 32'd1);
        check("mis_data", idata[0], 32'h00000013);
        check("mis_lat", 32'(lat), 32'd2);
        consume(0);
        start_fetch(0, 32'h40, lat);
        check("oor_err", 32'(rsp_err[0]), 32'd1);
        check("oor_data", idata[0], 32'h00000013);
        consume(0);
        load(0, 4'd15, 32'hABCD0123);
        start_fetch(0, 32'h3C, lat);
        check("top_err", 32'(rsp_err[0]), 32'd0);
        check("top_data", idata[0], 32'hABCD0123);
        consume(0);

        // Zero wait states with a same-edge load collision
        load(1, 4'd3, 32'h00C00193);
        req_valid[1] = 1'b1;
        iaddr[1]     = 32'hC;
        load_en[1]   = 1'b1;
        load_idx[1]  = 4'd3;
        load_data[1] = 32'hDEADBEEF;
        tick();
        req_valid[1] = 1'b0;
        load_en[1]   = 1'b0;
        check("col_valid", 32'(rsp_valid[1]), 32'd1);
        check("col_old", idata[1], 32'h00C00193);
        consume(1);
        start_fetch(1, 32'hC, lat);
        check("w0_lat", 32'(lat), 32'd1);
        check("w0_new", idata[1], 32'hDEADBEEF);
        consume(1);

        // Four wait states, then reset in the middle of WAIT
        load(2, 4'd5, 32'h12345678);
        req_valid[2] = 1'b1;
        iaddr[2]     = 32'h14;
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy[2]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy[2]), 32'd0);
        check("arst_ready", 32'(req_ready[2]), 32'd1);
        check("arst_valid", 32'(rsp_valid[2]), 32'd0);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid[2]) seen++;
        end
        check("drop_no_rsp", 32'(seen), 32'd0);
        start_fetch(2, 32'h14, lat);
        check("w4_lat", 32'(lat), 32'd5);
        check("w4_data", idata[2], 32'h12345678);
        consume(2);
        start_fetch(0, 32'h0, lat);
        check("keep_data", idata[0], 32'h00500093);
        consume(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
